// File: rtl/homography_sampler.sv
// Warp-pipeline reader: fetches source neighbours for one mapped coordinate and emits one pixel.
// Nearest-neighbour by default; define HOMOGRAPHY_SAMPLER_BILINEAR_EN for 4-tap bilinear.
module homography_sampler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned COORD_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned BORDER_VALUE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COORD_WIDTH-1:0] src_x,
  input  logic [COORD_WIDTH-1:0] src_y,
  input  logic [FRAC_WIDTH-1:0]  src_x_frac,
  input  logic [FRAC_WIDTH-1:0]  src_y_frac,
  input  logic [COORD_WIDTH-1:0] src_width,
  input  logic [COORD_WIDTH-1:0] src_height,
  output logic                   rd_req,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic                   rd_gnt,
  input  logic                   rd_valid,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_pixel,
  output logic                   out_oob
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CALC = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t                 state_r;
  logic [DATA_WIDTH-1:0]  p0_r;
  logic [COORD_WIDTH:0]   x_inc_s;
  logic [COORD_WIDTH:0]   y_inc_s;
  logic [COORD_WIDTH-1:0] x1_in_s;
  logic [COORD_WIDTH-1:0] y1_in_s;
  logic [COORD_WIDTH-1:0] ax_s;
  logic [COORD_WIDTH-1:0] ay_s;
  logic                   oob_s;
  logic [ADDR_WIDTH-1:0]  addr_s;
  logic                   unused_frac_s;

  // x < width is guaranteed on the in-frame path, so x+1 can only overshoot by exactly one.
  assign x_inc_s = {1'b0, src_x} + {{COORD_WIDTH{1'b0}}, 1'b1};
  assign y_inc_s = {1'b0, src_y} + {{COORD_WIDTH{1'b0}}, 1'b1};
  assign x1_in_s = (x_inc_s == {1'b0, src_width})  ? src_x : x_inc_s[COORD_WIDTH-1:0];
  assign y1_in_s = (y_inc_s == {1'b0, src_height}) ? src_y : y_inc_s[COORD_WIDTH-1:0];
  assign oob_s   = (src_x >= src_width) || (src_y >= src_height);
  assign addr_s  = ADDR_WIDTH'(ay_s) * ADDR_WIDTH'(src_width) + ADDR_WIDTH'(ax_s);
  assign unused_frac_s = ^{src_x_frac, src_y_frac};

`ifdef HOMOGRAPHY_SAMPLER_BILINEAR_EN
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + 18;
  localparam int unsigned Q_WIDTH   = ACC_WIDTH - 16;
  localparam logic [DATA_WIDTH-1:0] PIX_MAX = {DATA_WIDTH{1'b1}};

  logic [COORD_WIDTH-1:0] x_r;
  logic [COORD_WIDTH-1:0] y_r;
  logic [COORD_WIDTH-1:0] x1_r;
  logic [COORD_WIDTH-1:0] y1_r;
  logic [7:0]             fx_r;
  logic [7:0]             fy_r;
  logic [1:0]             k_r;
  logic [1:0]             k_next_s;
  logic [DATA_WIDTH-1:0]  p1_r;
  logic [DATA_WIDTH-1:0]  p2_r;
  logic [DATA_WIDTH-1:0]  p3_r;

  function automatic logic [DATA_WIDTH-1:0] bilerp(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] d,
    input logic [7:0]            fx,
    input logic [7:0]            fy
  );
    logic [8:0]           wx0;
    logic [8:0]           wx1;
    logic [8:0]           wy0;
    logic [8:0]           wy1;
    logic [ACC_WIDTH-1:0] acc;
    logic [Q_WIDTH-1:0]   q;
    wx0 = 9'd256 - {1'b0, fx};
    wx1 = {1'b0, fx};
    wy0 = 9'd256 - {1'b0, fy};
    wy1 = {1'b0, fy};
    acc = ACC_WIDTH'(a) * ACC_WIDTH'(wx0) * ACC_WIDTH'(wy0)
        + ACC_WIDTH'(b) * ACC_WIDTH'(wx1) * ACC_WIDTH'(wy0)
        + ACC_WIDTH'(c) * ACC_WIDTH'(wx0) * ACC_WIDTH'(wy1)
        + ACC_WIDTH'(d) * ACC_WIDTH'(wx1) * ACC_WIDTH'(wy1)
        + ACC_WIDTH'(17'd32768);
    q = acc[ACC_WIDTH-1:16];
    bilerp = (q > Q_WIDTH'(PIX_MAX)) ? PIX_MAX : q[DATA_WIDTH-1:0];
  endfunction

  assign k_next_s = k_r + 2'd1;

  // Address of the first neighbour comes from the inputs; later ones from the latched corner set.
  always_comb begin
    if (state_r == IDLE) begin
      ax_s = src_x;
      ay_s = src_y;
    end else begin
      ax_s = k_next_s[0] ? x1_r : x_r;
      ay_s = k_next_s[1] ? y1_r : y_r;
    end
  end
`else
  // Round-half-up on the top fraction bit, clamped to the last column/row.
  assign ax_s = src_x_frac[FRAC_WIDTH-1] ? x1_in_s : src_x;
  assign ay_s = src_y_frac[FRAC_WIDTH-1] ? y1_in_s : src_y;
`endif

  // Sampler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b0;
      rd_req    <= 1'b0;
      rd_addr   <= {ADDR_WIDTH{1'b0}};
      out_valid <= 1'b0;
      out_pixel <= {DATA_WIDTH{1'b0}};
      out_oob   <= 1'b0;
      p0_r      <= {DATA_WIDTH{1'b0}};
`ifdef HOMOGRAPHY_SAMPLER_BILINEAR_EN
      x_r       <= {COORD_WIDTH{1'b0}};
      y_r       <= {COORD_WIDTH{1'b0}};
      x1_r      <= {COORD_WIDTH{1'b0}};
      y1_r      <= {COORD_WIDTH{1'b0}};
      fx_r      <= 8'd0;
      fy_r      <= 8'd0;
      k_r       <= 2'd0;
      p1_r      <= {DATA_WIDTH{1'b0}};
      p2_r      <= {DATA_WIDTH{1'b0}};
      p3_r      <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (oob_s) begin
              out_pixel <= DATA_WIDTH'(BORDER_VALUE);
              out_oob   <= 1'b1;
              out_valid <= 1'b1;
              state_r   <= OUT;
            end else begin
              out_oob <= 1'b0;
              rd_req  <= 1'b1;
              rd_addr <= addr_s;
              state_r <= REQ;
`ifdef HOMOGRAPHY_SAMPLER_BILINEAR_EN
              x_r  <= src_x;
              y_r  <= src_y;
              x1_r <= x1_in_s;
              y1_r <= y1_in_s;
              fx_r <= src_x_frac[FRAC_WIDTH-1 -: 8];
              fy_r <= src_y_frac[FRAC_WIDTH-1 -: 8];
              k_r  <= 2'd0;
`endif
            end
          end
        end
        REQ: begin
          if (rd_gnt) begin
            rd_req  <= 1'b0;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (rd_valid) begin
`ifdef HOMOGRAPHY_SAMPLER_BILINEAR_EN
            case (k_r)
              2'd0:    p0_r <= rd_data;
              2'd1:    p1_r <= rd_data;
              2'd2:    p2_r <= rd_data;
              2'd3:    p3_r <= rd_data;
              default: p0_r <= rd_data;
            endcase
            if (k_r == 2'd3) begin
              state_r <= CALC;
            end else begin
              k_r     <= k_next_s;
              rd_req  <= 1'b1;
              rd_addr <= addr_s;
              state_r <= REQ;
            end
`else
            p0_r    <= rd_data;
            state_r <= CALC;
`endif
          end
        end
        CALC: begin
`ifdef HOMOGRAPHY_SAMPLER_BILINEAR_EN
          out_pixel <= bilerp(p0_r, p1_r, p2_r, p3_r, fx_r, fy_r);
`else
          out_pixel <= p0_r;
`endif
          out_valid <= 1'b1;
          state_r   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_homography_sampler.sv
// Scoreboard bench for homography_sampler on a 4x4 frame with p(x,y) = 10x + 40y.
module tb_homography_sampler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] src_x;
  logic [15:0] src_y;
  logic [15:0] src_x_frac;
  logic [15:0] src_y_frac;
  logic [15:0] src_width;
  logic [15:0] src_height;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic        out_oob;

  logic        mem_valid;
  logic        late_valid;
  bit          stall;
  bit          hold_mode;
  bit          flush;
  bit          pending;

  int          n_cmp;
  int          n_fail;

  logic [8:0]  exp_q[$];
  logic [31:0] addr_q[$];

  typedef struct {
    int x; int y; int xf; int yf;
    int pix; int oob; int lat; int na;
    int a0; int a1; int a2; int a3;
  } vec_t;

  vec_t vecs[8];

  assign rd_valid = mem_valid | late_valid;

  homography_sampler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src_x      (src_x),
    .src_y      (src_y),
    .src_x_frac (src_x_frac),
    .src_y_frac (src_y_frac),
    .src_width  (src_width),
    .src_height (src_height),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_oob    (out_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Memory model: grant/valid with optional random 0-7 cycle delays; checks request order.
  initial begin
    logic        granted;
    logic [31:0] a;
    logic [31:0] pend_addr;
    int          gdelay;
    int          vdelay;
    int          ia;
    rd_gnt    = 1'b1;
    mem_valid = 1'b0;
    rd_data   = 8'd0;
    pending   = 1'b0;
    gdelay    = 0;
    vdelay    = 0;
    pend_addr = 32'd0;
    forever begin
      @(posedge clk);
      granted = rd_req && rd_gnt;
      a       = rd_addr;
      #1;
      mem_valid = 1'b0;
      if (flush) pending = 1'b0;
      if (granted) begin
        if (addr_q.size() == 0) chk("rd_req_unexpected", 64'(granted), 64'd0);
        else chk("rd_addr", 64'(a), 64'(addr_q.pop_front()));
        pending   = 1'b1;
        pend_addr = a;
        vdelay    = stall ? int'($urandom_range(0, 7)) : 0;
        gdelay    = stall ? int'($urandom_range(0, 7)) : 0;
      end
      if (pending && !hold_mode) begin
        if (vdelay == 0) begin
          ia        = int'(pend_addr);
          rd_data   = 8'(10 * (ia % 4) + 40 * (ia / 4));
          mem_valid = 1'b1;
          pending   = 1'b0;
        end else begin
          vdelay--;
        end
      end
      if (gdelay == 0) rd_gnt = 1'b1;
      else begin
        rd_gnt = 1'b0;
        gdelay--;
      end
    end
  end

  // Output monitor: pops the scoreboard on every accepted output pixel.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_unexpected", 64'(out_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_pixel", 64'(out_pixel), 64'(e[8:1]));
          chk("out_oob", 64'(out_oob), 64'(e[0]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input vec_t v);
    logic [7:0] p;
    logic       o;
    p = v.pix[7:0];
    o = v.oob[0];
    exp_q.push_back({p, o});
    if (v.na >= 1) addr_q.push_back(32'(v.a0));
    if (v.na >= 2) addr_q.push_back(32'(v.a1));
    if (v.na >= 3) addr_q.push_back(32'(v.a2));
    if (v.na >= 4) addr_q.push_back(32'(v.a3));
    src_x      = v.x[15:0];
    src_y      = v.y[15:0];
    src_x_frac = v.xf[15:0];
    src_y_frac = v.yf[15:0];
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  task automatic run_vec(input int i, input bit check_lat, input int hold);
    vec_t v;
    int   n;
    v = vecs[i];
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
    issue(v);
    n = 1;
    while (!out_valid && n < 400) begin @(posedge clk); #1; n++; end
    if (check_lat) chk("latency", 64'(n), 64'(v.lat));
    else if (!out_valid) chk("out_valid_wait", 64'(out_valid), 64'd1);
    for (int c = 0; c < hold; c++) begin
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_pixel", 64'(out_pixel), 64'(v.pix));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (out_valid) chk("retire", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
`ifdef HOMOGRAPHY_SAMPLER_BILINEAR_EN
    vecs[0] = '{1, 2, 32'h8000, 32'h8000, 115, 0, 10, 4,  9, 10, 13, 14};
    vecs[1] = '{3, 3, 32'h8000, 32'h8000, 150, 0, 10, 4, 15, 15, 15, 15};
    vecs[2] = '{4, 0, 32'h0000, 32'h0000,   0, 1,  1, 0,  0,  0,  0,  0};
    vecs[3] = '{0, 0, 32'h0000, 32'h0000,   0, 0, 10, 4,  0,  1,  4,  5};
    vecs[4] = '{2, 1, 32'h7FFF, 32'h8000,  85, 0, 10, 4,  6,  7, 10, 11};
    vecs[5] = '{0, 4, 32'hFFFF, 32'h0000,   0, 1,  1, 0,  0,  0,  0,  0};
    vecs[6] = '{3, 0, 32'hFFFF, 32'h0000,  30, 0, 10, 4,  3,  3,  7,  7};
    vecs[7] = '{1, 1, 32'h4000, 32'hC000,  83, 0, 10, 4,  5,  6,  9, 10};
`else
    vecs[0] = '{1, 2, 32'h8000, 32'h8000, 140, 0, 4, 1, 14, 0, 0, 0};
    vecs[1] = '{3, 3, 32'h8000, 32'h8000, 150, 0, 4, 1, 15, 0, 0, 0};
    vecs[2] = '{4, 0, 32'h0000, 32'h0000,   0, 1, 1, 0,  0, 0, 0, 0};
    vecs[3] = '{0, 0, 32'h0000, 32'h0000,   0, 0, 4, 1,  0, 0, 0, 0};
    vecs[4] = '{2, 1, 32'h7FFF, 32'h8000, 100, 0, 4, 1, 10, 0, 0, 0};
    vecs[5] = '{0, 4, 32'hFFFF, 32'h0000,   0, 1, 1, 0,  0, 0, 0, 0};
    vecs[6] = '{3, 0, 32'hFFFF, 32'h0000,  30, 0, 4, 1,  3, 0, 0, 0};
    vecs[7] = '{1, 1, 32'h4000, 32'hC000,  90, 0, 4, 1,  9, 0, 0, 0};
`endif
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    src_x      = 16'd0;
    src_y      = 16'd0;
    src_x_frac = 16'd0;
    src_y_frac = 16'd0;
    src_width  = 16'd4;
    src_height = 16'd4;
    out_ready  = 1'b1;
    late_valid = 1'b0;
    stall      = 1'b0;
    hold_mode  = 1'b0;
    flush      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_rd_req", 64'(rd_req), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pixel", 64'(out_pixel), 64'd0);
    chk("rst_out_oob", 64'(out_oob), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++) run_vec(i, 1'b1, 0);
    run_vec(0, 1'b1, 5);

    stall = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(i, 1'b0, 0);
    stall = 1'b0;

    // Reset while waiting for read data, then a stray rd_valid after release.
    hold_mode = 1'b1;
    issue(vecs[0]);
    n = 0;
    while (!pending && n < 50) begin @(posedge clk); #1; n++; end
    chk("reached_wait", 64'(pending), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_rd_req", 64'(rd_req), 64'd0);
    chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_pixel", 64'(out_pixel), 64'd0);
    chk("mid_rst_out_oob", 64'(out_oob), 64'd0);
    exp_q.delete();
    addr_q.delete();
    flush     = 1'b1;
    hold_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush = 1'b0;
    @(posedge clk); #1;
    late_valid = 1'b1;
    @(posedge clk); #1;
    late_valid = 1'b0;
    chk("late_rd_req", 64'(rd_req), 64'd0);
    chk("late_out_valid", 64'(out_valid), 64'd0);
    chk("late_in_ready", 64'(in_ready), 64'd1);
    run_vec(4, 1'b1, 0);
    run_vec(0, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
